// File: rtl/align_sticky_pipe.sv
// align_sticky_pipe: two-stage right-alignment shifter with sticky output.
// Stage 1 registers the shifted significand and per-chunk ORs of the bits
// shifted out. Stage 2 reduces the chunk ORs to one sticky bit, optionally
// folds it into the LSB, and owns the output registers.
module align_sticky_pipe #(
  parameter int W     = 55,
  parameter int SW    = 6,
  parameter int CHUNK = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_sig,
  input  logic [SW-1:0]    in_sh,
  input  logic             in_fold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sig,
  output logic             out_sticky,
  output logic [CNT_W-1:0] sticky_cnt
);
  localparam int NCH = (W + CHUNK - 1) / CHUNK;
  localparam int PW  = NCH * CHUNK;

  logic [W-1:0]   w_mask;
  logic [W-1:0]   w_masked;
  logic [W-1:0]   w_shifted;
  logic [PW-1:0]  w_pad;
  logic [NCH-1:0] w_chunk_or;
  logic           w_adv1, w_adv2, w_s1_sticky;

  logic           r_s1_valid, r_s1_fold;
  logic [NCH-1:0] r_s1_chunks;
  logic [W-1:0]   r_s1_sig;
  logic           r_s2_valid, r_out_sticky;
  logic [W-1:0]   r_out_sig;
  logic [CNT_W-1:0] r_cnt;

  // Bit i of the input falls off the end when i < shift distance.
  for (genvar g = 0; g < W; g++) begin : g_mask
    assign w_mask[g] = (int'(in_sh) > g);
  end

  assign w_masked = in_sig & w_mask;
  assign w_pad    = PW'(w_masked);

  // Partial OR per chunk; the top chunk is zero-padded.
  for (genvar c = 0; c < NCH; c++) begin : g_chunk
    assign w_chunk_or[c] = |w_pad[c*CHUNK +: CHUNK];
  end

  // Shifts of W or more clear the word entirely.
  assign w_shifted = (int'(in_sh) >= W) ? '0 : (in_sig >> in_sh);

  assign w_adv2      = !r_s2_valid | out_ready;
  assign w_adv1      = !r_s1_valid | w_adv2;
  assign in_ready    = rst_n & w_adv1;
  assign w_s1_sticky = |r_s1_chunks;

  // Stage 1: capture a new beat whenever the stage advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_fold   <= 1'b0;
      r_s1_chunks <= '0;
      r_s1_sig    <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_fold   <= in_fold;
        r_s1_chunks <= w_chunk_or;
        r_s1_sig    <= w_shifted;
      end
    end
  end

  // Stage 2: final sticky reduction and fold into the output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_out_sig    <= '0;
      r_out_sticky <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_sticky <= w_s1_sticky;
        r_out_sig    <= r_s1_fold ? (r_s1_sig | W'(w_s1_sticky)) : r_s1_sig;
      end
    end
  end

  // Saturating count of delivered sticky beats.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (r_s2_valid && out_ready && r_out_sticky && (r_cnt != '1))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign out_valid  = r_s2_valid;
  assign out_sig    = r_out_sig;
  assign out_sticky = r_out_sticky;
  assign sticky_cnt = r_cnt;
endmodule

// File: tb/tb_align_sticky_pipe.sv
// Bench for align_sticky_pipe: directed cases plus random traffic, scored
// against an arithmetic reference model and a queue of expected beats.
module tb_align_sticky_pipe;
  localparam int W     = 55;
  localparam int SW    = 6;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_fold;
  logic [W-1:0]     in_sig;
  logic [SW-1:0]    in_sh;
  logic             out_valid, out_ready, out_sticky;
  logic [W-1:0]     out_sig;
  logic [CNT_W-1:0] sticky_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W:0] m_q[$];   // {sticky, sig}
  int         m_cnt;
  logic       prev_stall;
  logic [W-1:0] prev_sig;
  logic       prev_st;

  align_sticky_pipe #(.W(W), .SW(SW), .CHUNK(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sig(in_sig), .in_sh(in_sh), .in_fold(in_fold),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sig(out_sig), .out_sticky(out_sticky),
    .sticky_cnt(sticky_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on a 64-bit copy of the significand.
  function automatic logic [W:0] ref_align(input logic [W-1:0] sig, input int sh, input logic fold);
    logic [63:0] s, r;
    logic        st;
    s = 64'(sig);
    if (sh >= W) begin
      r  = 64'd0;
      st = (s != 64'd0);
    end else begin
      r  = s >> sh;
      st = ((s & ((64'd1 << sh) - 64'd1)) != 64'd0);
    end
    if (fold) r = r | 64'(st);
    return {st, r[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_sig();
    return W'({$urandom, $urandom});
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_cnt      = 0;
    prev_stall = 1'b0;
  endtask

  // Inputs are already applied; evaluate this cycle's handshakes, then let
  // the rising edge happen and return at the next falling edge.
  task automatic tick();
    logic [W:0] e;
    #1;
    if (!rst_n) begin
      chk("in_ready_in_reset", 64'(in_ready), 64'd0);
    end else begin
      chk("sticky_cnt", 64'(sticky_cnt), 64'(m_cnt));
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_sig", 64'(out_sig), 64'(prev_sig));
        chk("stall_sticky", 64'(out_sticky), 64'(prev_st));
      end
      if (out_valid && out_ready) begin
        if (m_q.size() == 0) begin
          chk("spurious_beat", 64'd1, 64'd0);
        end else begin
          e = m_q.pop_front();
          chk("out_sig", 64'(out_sig), 64'(e[W-1:0]));
          chk("out_sticky", 64'(out_sticky), 64'(e[W]));
          if (e[W] && m_cnt < CMAX) m_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sig   = out_sig;
      prev_st    = out_sticky;
      if (in_valid && in_ready) m_q.push_back(ref_align(in_sig, int'(in_sh), in_fold));
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] s, input int sh, input logic f, input logic ordy);
    in_valid  = v;
    in_sig    = s;
    in_sh     = SW'(sh);
    in_fold   = f;
    out_ready = ordy;
  endtask

  // One beat into an empty pipe: checks 2-cycle latency and the result.
  task automatic beat_direct(input logic [W-1:0] s, input int sh, input logic f,
                             input logic [W-1:0] xs, input logic xst);
    drive(1'b1, s, sh, f, 1'b1);
    tick();
    drive(1'b0, '0, 0, 1'b0, 1'b1);
    #1 chk("latency_not_yet", 64'(out_valid), 64'd0);
    tick();
    #1;
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("direct_sig", 64'(out_sig), 64'(xs));
    chk("direct_sticky", 64'(out_sticky), 64'(xst));
    tick();
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    drive(1'b0, '0, 0, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    tick();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sig", 64'(out_sig), 64'd0);
    chk("rst_out_sticky", 64'(out_sticky), 64'd0);
    chk("rst_cnt", 64'(sticky_cnt), 64'd0);
    rst_n = 1'b1;
    #1 chk("ready_after_release", 64'(in_ready), 64'd1);

    // Directed arithmetic cases.
    beat_direct(W'(64'h10), 4, 1'b0, W'(64'h1), 1'b0);
    beat_direct(W'(64'h10), 5, 1'b0, W'(64'h0), 1'b1);
    beat_direct(W'(64'h10), 5, 1'b1, W'(64'h1), 1'b1);
    beat_direct(W'(64'h1) << (W-1), 63, 1'b0, W'(64'h0), 1'b1);
    beat_direct(W'(64'h1), 0, 1'b1, W'(64'h1), 1'b0);
    beat_direct(W'(64'h3), 55, 1'b0, W'(64'h0), 1'b1);

    // Fill with out_ready=0: two accepts, then back-pressure.
    drive(1'b1, W'(64'hF0), 1, 1'b0, 1'b0); tick();
    drive(1'b1, W'(64'hF0), 2, 1'b0, 1'b0); tick();
    drive(1'b1, W'(64'hF0), 3, 1'b0, 1'b0);
    #1 chk("full_in_ready", 64'(in_ready), 64'd0);
    tick(); tick(); tick();
    drive(1'b1, W'(64'hF0), 3, 1'b0, 1'b1); tick();
    drive(1'b0, '0, 0, 1'b0, 1'b1);
    #1 chk("no_bubble_1", 64'(out_valid), 64'd1);
    tick();
    #1 chk("no_bubble_2", 64'(out_valid), 64'd1);
    tick();
    tick();
    chk("drain_4", 64'(m_q.size()), 64'd0);

    // Saturation: five sticky beats, then one clean beat.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, W'(64'h1F), 3, 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, W'(64'h100), 1, 1'b0, 1'b1); tick();
    drive(1'b0, '0, 0, 1'b0, 1'b1); tick(); tick(); tick();
    chk("cnt_saturated", 64'(sticky_cnt), 64'd3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int sh;
      case ($urandom_range(0, 5))
        0:       sh = 0;
        1:       sh = $urandom_range(W, 63);
        default: sh = $urandom_range(0, 63);
      endcase
      drive($urandom_range(0, 3) != 0, rand_sig(), sh, 1'($urandom),
            $urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, '0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("drain_rand", 64'(m_q.size()), 64'd0);

    // Reset while both stages are full and stalled.
    drive(1'b1, W'(64'hFF), 4, 1'b0, 1'b0); tick();
    drive(1'b1, W'(64'hFF), 4, 1'b0, 1'b0); tick();
    rst_n = 1'b0;
    tick();
    model_clear();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_cnt", 64'(sticky_cnt), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, '0, 0, 1'b0, 1'b1);
    #1 chk("midrst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1 chk("no_stale_beat", 64'(out_valid), 64'd0);
    end
    beat_direct(W'(64'h8), 3, 1'b0, W'(64'h1), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
